// File: rtl/rcn_ring_port.sv
// rcn_ring_port: ring attachment point for one RCN master node.
// Drains the request FIFO onto the ring whenever a slot is free. Ejects
// responses addressed to this master into the response FIFO. Provides one
// register stage on the ring and a starvation indicator.
// Optional build macro RCN_RING_PORT_STATS_EN adds the inj_count and
// ej_count saturating activity counters.
module rcn_ring_port #(
  parameter logic [5:0] MASTER_ID    = 6'd0,
  parameter logic [7:0] STARVE_LIMIT = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [68:0] ring_in,
  output logic [68:0] ring_out,
  input  logic [68:0] req_data,
  output logic        req_pop,
  output logic [68:0] rsp_data,
  output logic        rsp_push,
  input  logic        rsp_full,
  input  logic        inject_en,
  output logic        starved
`ifdef RCN_RING_PORT_STATS_EN
  ,
  output logic [15:0] inj_count,
  output logic [15:0] ej_count
`endif
);

  logic [68:0] ring_q, ring_d;
  logic [7:0]  blk_cnt_q, blk_cnt_d;
  logic        starved_q;
  logic        eject;
  logic        slot_free;

  // Ejection, slot availability and injection decisions for the current cycle.
  // Reset suppresses both FIFO handshakes so nothing is pushed or popped.
  always_comb begin
    eject     = ring_in[68] & ~ring_in[67] & (ring_in[65:60] == MASTER_ID)
                & ~rsp_full & ~rst;
    slot_free = ~ring_in[68] | eject;
    req_pop   = slot_free & req_data[68] & inject_en & ~rst;
  end

  assign rsp_push = eject;
  assign rsp_data = ring_in;
  assign ring_out = ring_q;
  assign starved  = starved_q;

  // Next ring slot: through-traffic keeps its slot; otherwise a popped request fills it.
  always_comb begin
    ring_d = 69'd0;
    if (ring_in[68] && !eject)
      ring_d = ring_in;
    else if (req_pop)
      ring_d = req_data;
  end

  // Starvation counter: counts consecutive cycles a pending request is blocked.
  // Any pop, an empty FIFO or disabled injection returns it to zero.
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (req_pop || !req_data[68] || !inject_en)
      blk_cnt_d = 8'd0;
    else if (!slot_free && (blk_cnt_q != STARVE_LIMIT))
      blk_cnt_d = blk_cnt_q + 8'd1;
  end

  // Ring register stage, starvation state and the flag derived from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ring_q    <= 69'd0;
      blk_cnt_q <= 8'd0;
      starved_q <= 1'b0;
    end else begin
      ring_q    <= ring_d;
      blk_cnt_q <= blk_cnt_d;
      starved_q <= (blk_cnt_d == STARVE_LIMIT);
    end
  end

`ifdef RCN_RING_PORT_STATS_EN
  logic [15:0] inj_cnt_q, ej_cnt_q;

  // Saturating activity counters for injected requests and ejected responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      inj_cnt_q <= 16'd0;
      ej_cnt_q  <= 16'd0;
    end else begin
      if (req_pop && (inj_cnt_q != 16'hFFFF))
        inj_cnt_q <= inj_cnt_q + 16'd1;
      if (rsp_push && (ej_cnt_q != 16'hFFFF))
        ej_cnt_q <= ej_cnt_q + 16'd1;
    end
  end

  assign inj_count = inj_cnt_q;
  assign ej_count  = ej_cnt_q;
`endif

endmodule

// File: tb/tb_rcn_ring_port.sv
// Directed testbench for rcn_ring_port (MASTER_ID=0, STARVE_LIMIT=4).
module tb_rcn_ring_port;

  logic        clk;
  logic        rst;
  logic [68:0] ring_in;
  logic [68:0] ring_out;
  logic [68:0] req_data;
  logic        req_pop;
  logic [68:0] rsp_data;
  logic        rsp_push;
  logic        rsp_full;
  logic        inject_en;
  logic        starved;
`ifdef RCN_RING_PORT_STATS_EN
  logic [15:0] inj_count;
  logic [15:0] ej_count;
`endif

  int npass = 0;
  int ntotal = 0;

  rcn_ring_port #(
    .MASTER_ID    (6'd0),
    .STARVE_LIMIT (8'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ring_in   (ring_in),
    .ring_out  (ring_out),
    .req_data  (req_data),
    .req_pop   (req_pop),
    .rsp_data  (rsp_data),
    .rsp_push  (rsp_push),
    .rsp_full  (rsp_full),
    .inject_en (inject_en),
    .starved   (starved)
`ifdef RCN_RING_PORT_STATS_EN
    ,
    .inj_count (inj_count),
    .ej_count  (ej_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packet builders: {valid, req/rsp, spare, id, payload}
  function automatic logic [68:0] mk_req(input logic [5:0] id, input logic [59:0] pl);
    return {1'b1, 1'b1, 1'b0, id, pl};
  endfunction

  function automatic logic [68:0] mk_rsp(input logic [5:0] id, input logic [59:0] pl);
    return {1'b1, 1'b0, 1'b0, id, pl};
  endfunction

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock, then settle 1ns past the edge before driving/sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [68:0] pa, pb, pc, r1, r2, r3, r4, rsp0, req0;

  initial begin
    pa   = mk_req(6'd0, 60'hAAA_0001);
    pb   = mk_req(6'd0, 60'hBBB_0002);
    pc   = mk_req(6'd0, 60'hCCC_0003);
    r1   = mk_req(6'd5, 60'h111);
    r2   = mk_req(6'd5, 60'h222);
    r3   = mk_req(6'd5, 60'h333);
    r4   = mk_req(6'd5, 60'h444);
    rsp0 = mk_rsp(6'd0, 60'h5A5A);
    req0 = mk_req(6'd0, 60'h7777);

    // Reset: handshakes forced low even with valid inputs; ring packet discarded.
    rst = 1'b1; ring_in = rsp0; req_data = pa; rsp_full = 1'b0; inject_en = 1'b1;
    #1;
    chk("rst_pop", {68'd0, req_pop}, 69'd0);
    chk("rst_push", {68'd0, rsp_push}, 69'd0);
    tick();
    tick();
    chk("rst_ring_out", ring_out, 69'd0);
    chk("rst_starved", {68'd0, starved}, 69'd0);

    // Empty ring burst A, B, C.
    rst = 1'b0; ring_in = 69'd0; req_data = pa; #1;
    chk("burst_pop_a", {68'd0, req_pop}, 69'd1);
    tick();
    chk("burst_out_a", ring_out, pa);
    req_data = pb; #1;
    chk("burst_pop_b", {68'd0, req_pop}, 69'd1);
    tick();
    chk("burst_out_b", ring_out, pb);
    req_data = pc; #1;
    chk("burst_pop_c", {68'd0, req_pop}, 69'd1);
    tick();
    chk("burst_out_c", ring_out, pc);
    req_data = 69'd0; #1;
    chk("burst_pop_idle", {68'd0, req_pop}, 69'd0);
    tick();
    chk("burst_out_zero", ring_out, 69'd0);

    // Ring busy with foreign requests: blocked, pass-through, starvation.
    req_data = pa; ring_in = r1; #1;
    chk("blk_pop_1", {68'd0, req_pop}, 69'd0);
    chk("blk_push_1", {68'd0, rsp_push}, 69'd0);
    tick();
    chk("blk_out_1", ring_out, r1);
    chk("blk_starved_1", {68'd0, starved}, 69'd0);
    ring_in = r2; #1;
    chk("blk_pop_2", {68'd0, req_pop}, 69'd0);
    tick();
    chk("blk_out_2", ring_out, r2);
    ring_in = r3; tick();
    chk("blk_out_3", ring_out, r3);
    chk("blk_starved_3", {68'd0, starved}, 69'd0);
    ring_in = r4; #1;
    chk("blk_pop_4", {68'd0, req_pop}, 69'd0);
    tick();
    chk("blk_out_4", ring_out, r4);
    chk("blk_starved_4", {68'd0, starved}, 69'd1);
    ring_in = r1; tick();
    chk("blk_starved_sat", {68'd0, starved}, 69'd1);

    // Free slot: inject, starvation clears next cycle.
    ring_in = 69'd0; #1;
    chk("free_pop", {68'd0, req_pop}, 69'd1);
    tick();
    chk("free_out", ring_out, pa);
    chk("free_starved", {68'd0, starved}, 69'd0);

    // Matching response with room: eject and inject together.
    ring_in = rsp0; req_data = pb; rsp_full = 1'b0; #1;
    chk("ej_push", {68'd0, rsp_push}, 69'd1);
    chk("ej_data", rsp_data, rsp0);
    chk("ej_pop", {68'd0, req_pop}, 69'd1);
    tick();
    chk("ej_out", ring_out, pb);

    // Matching response while FIFO full: circulates, no injection.
    rsp_full = 1'b1; #1;
    chk("full_push", {68'd0, rsp_push}, 69'd0);
    chk("full_pop", {68'd0, req_pop}, 69'd0);
    chk("full_data", rsp_data, rsp0);
    tick();
    chk("full_out", ring_out, rsp0);

    // Request with our own ID is never ejected.
    rsp_full = 1'b0; ring_in = req0; #1;
    chk("reqid_push", {68'd0, rsp_push}, 69'd0);
    chk("reqid_pop", {68'd0, req_pop}, 69'd0);
    tick();
    chk("reqid_out", ring_out, req0);

    // inject_en low with empty ring: no pop.
    ring_in = 69'd0; inject_en = 1'b0; #1;
    chk("inj_dis_pop", {68'd0, req_pop}, 69'd0);
    tick();
    chk("inj_dis_out", ring_out, 69'd0);
    inject_en = 1'b1;

    // Build blk_cnt=3 with a valid ring_out, then reset.
    ring_in = r1; tick();
    ring_in = r2; tick();
    ring_in = r3; tick();
    chk("pre_rst_out", ring_out, r3);
    chk("pre_rst_starved", {68'd0, starved}, 69'd0);
`ifdef RCN_RING_PORT_STATS_EN
    chk("pre_rst_inj", {53'd0, inj_count}, 69'd5);
    chk("pre_rst_ej", {53'd0, ej_count}, 69'd1);
`endif
    rst = 1'b1; ring_in = 69'd0; #1;
    chk("rst2_pop", {68'd0, req_pop}, 69'd0);
    tick();
    chk("rst2_out", ring_out, 69'd0);
    chk("rst2_starved", {68'd0, starved}, 69'd0);
`ifdef RCN_RING_PORT_STATS_EN
    chk("rst2_inj", {53'd0, inj_count}, 69'd0);
    chk("rst2_ej", {53'd0, ej_count}, 69'd0);
`endif

    // After reset the blocked count restarted: three blocked cycles stay unstarved.
    rst = 1'b0; ring_in = r1; tick();
    ring_in = r2; tick();
    ring_in = r3; tick();
    chk("post_rst_starved", {68'd0, starved}, 69'd0);
    ring_in = r4; tick();
    chk("post_rst_starved4", {68'd0, starved}, 69'd1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/rcn_ring_port.md
Name: rcn_ring_port

Overview:
- Ring attachment point for one RCN master node; 69-bit packets, bit [68] = valid.
- Downstream of the master's request FIFO: drains it onto the ring whenever a slot is free.
- Upstream of the master's response FIFO: ejects responses addressed to this master from the ring and pushes them into that FIFO.
- Provides a one-register ring stage and a starvation indicator.

Parameters:
- MASTER_ID, 6'd0, ID of this master; compared against packet field [65:60].
- STARVE_LIMIT, 8'd64, consecutive blocked-injection cycles before starved asserts; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- ring_in  in  69  ring packet from the upstream node.
- ring_out  out  69  registered ring packet to the downstream node.
- req_data  in  69  request FIFO head; [68] = FIFO non-empty.
- req_pop  out  1  combinational pop to the request FIFO.
- rsp_data  out  69  response to the response FIFO; equals ring_in.
- rsp_push  out  1  combinational push to the response FIFO.
- rsp_full  in  1  response FIFO full.
- inject_en  in  1  enables injection when 1.
- starved  out  1  registered; injection blocked for at least STARVE_LIMIT cycles.

Behaviour:
- Packet fields: [68] valid, [67] request (1) / response (0), [65:60] master ID.
- eject (combinational) = ring_in[68] & !ring_in[67] & (ring_in[65:60] == MASTER_ID) & !rsp_full.
- rsp_push = eject.
- rsp_data = ring_in, unconditionally.
- slot_free = !ring_in[68] | eject.
- req_pop (combinational) = slot_free & req_data[68] & inject_en.
  - Consumed in the same cycle as the FIFO's combinational head.
- ring_out next-value priority:
  1. ring_in[68] & !eject: pass through, ring_out <= ring_in.
  2. req_pop: ring_out <= req_data.
  3. Otherwise: ring_out <= 69'd0.
- Latency: exactly one clk through the port for both passed and injected packets.
- Matching response while rsp_full=1: not ejected; passes through and circulates the ring. Never dropped; never duplicated.
- Eject and inject in the same cycle are legal: the freed slot carries the injected request immediately.
- Request packets ([67]=1) are never ejected, regardless of ID.
- Starvation counter blk_cnt (8-bit):
  - States: IDLE (blk_cnt==0) and BLOCKED.
  - Increments when req_data[68] & inject_en & !slot_free.
  - Clears to 0 on any req_pop, or when req_data[68]=0 or inject_en=0.
  - Saturates at STARVE_LIMIT.
  - starved <= (next blk_cnt == STARVE_LIMIT).
  - Deasserts the cycle after the first successful injection.
- Reset (synchronous, takes priority over every other assignment):
  - ring_out=0, blk_cnt=0, starved=0.
  - req_pop and rsp_push are forced 0 while rst=1.
  - A packet on ring_in during the reset cycle is discarded.
- inject_en=0 mid-burst: no further pops; ring traffic is unaffected.

Optional Feature:
- Macro: RCN_RING_PORT_STATS_EN.
- Defined:
  - Adds output inj_count (16-bit) and output ej_count (16-bit).
  - Each is a registered, saturating counter of req_pop and rsp_push cycles respectively.
  - Both clear on rst.
  - Saturate at 16'hFFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Empty ring; req_data valid for 3 cycles with distinct payloads A, B, C; inject_en=1
  -> req_pop=1 on 3 consecutive cycles; ring_out = A, B, C one cycle later each; then ring_out=0.
- ring_in continuously valid request packets from ID 5; MASTER_ID=0; req_data valid; STARVE_LIMIT=4
  -> req_pop=0 throughout; ring_out mirrors ring_in delayed by 1; starved=1 on the 4th blocked cycle.
- ring_in invalid for one cycle after the starvation test above
  -> req_pop=1 that cycle; starved=0 on the next cycle.
- ring_in response with ID=MASTER_ID, rsp_full=0, req_data valid
  -> rsp_push=1 with rsp_data=ring_in; req_pop=1 the same cycle; ring_out = injected request next cycle.
- Same response with rsp_full=1
  -> rsp_push=0; ring_out = that response next cycle; no injection.
- rst=1 asserted while ring_out is valid and blk_cnt=3
  -> next cycle ring_out=0, starved=0, req_pop=0; with the stats macro defined, inj_count=0 and ej_count=0.
